// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types, arbiter defaults and helpers
// Purpose: common definitions for the FIFO read-side blocks.
//   W_DEPTH / addr_t : FIFO depth and pointer type
//   *_DEF            : fifo_rd_arbiter parameter defaults
//   arb_state_t      : read arbiter FSM states
//   id_width()       : requester index width, never below 1 bit
package fifo_pkg;

  localparam int W_DEPTH = 16;
  typedef logic [$clog2(W_DEPTH)-1:0] addr_t;

  localparam int N_REQ_DEF     = 4;
  localparam int MAX_BURST_DEF = 4;
  localparam int RD_LAT_DEF    = 1;
  localparam int BURST_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// rtl/fifo_rd_arbiter_rr_pick.sv - combinational round-robin priority picker
// Purpose: find the first set request at or after a start index, wrapping.
// Ports:
//   req   : request vector
//   start : index searched first
//   valid : at least one request is set
//   idx   : index of the winning request (0 when valid=0)
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  // Scan offsets from the far end down, so the smallest offset from start
  // is the last assignment and therefore the winner.
  always_comb begin
    logic [ID_W-1:0] pos;
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = ID_W'((int'(start) + i) % N_REQ);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin read arbiter in front of a FIFO
// Purpose: grants one requester per cycle a FIFO pop, with bounded bursts,
//   stalls while the FIFO is empty and reports read data return.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   req         : per-requester read request (level)
//   empty_flag  : FIFO empty indication
//   pop, gnt    : registered pop strobe and one-hot grant
//   rd_valid    : read data present, RD_LAT cycles after a pop
//   rd_id       : requester owning the rd_valid data
//   led_error   : requests pending while the FIFO is empty
module fifo_rd_arbiter
  import fifo_pkg::*;
#(
  parameter  int N_REQ     = N_REQ_DEF,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  parameter  int RD_LAT    = RD_LAT_DEF,
  localparam int ID_W      = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             empty_flag,
  output logic             pop,
  output logic [N_REQ-1:0] gnt,
  output logic             rd_valid,
  output logic [ID_W-1:0]  rd_id,
  output logic             led_error
);

  arb_state_t         state_q, state_d;
  logic               pop_q, pop_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]    start;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic               repeat_ok;

  logic [RD_LAT-1:0]  vld_pipe;
  logic [ID_W-1:0]    id_pipe [RD_LAT];

  assign start = (last_q == ID_W'(N_REQ - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .start (start),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // burst_cnt == 0 means no owner yet, so reset does not hand the
  // first grant to last_winner = N_REQ-1.
  assign repeat_ok = (cnt_q != '0) && (cnt_q < BURST_W'(MAX_BURST)) && req[last_q];

  // The decision is the same from every state: empty blocks, no request
  // idles, otherwise grant. The state only drives led_error.
  always_comb begin
    state_d = IDLE;
    pop_d   = 1'b0;
    gnt_d   = '0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (pick_valid && empty_flag) begin
      state_d = STALL;
    end else if (pick_valid) begin
      state_d = GRANT;
      pop_d   = 1'b1;
      if (repeat_ok) begin
        gnt_d[last_q] = 1'b1;
        cnt_d         = cnt_q + 1'b1;
      end else begin
        gnt_d[pick_idx] = 1'b1;
        last_d          = pick_idx;
        // Wrapping back to the same sole requester counts as a repeat.
        if (pick_idx == last_q) begin
          cnt_d = (cnt_q < BURST_W'(MAX_BURST)) ? cnt_q + 1'b1 : cnt_q;
        end else begin
          cnt_d = BURST_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pop_q   <= 1'b0;
      gnt_q   <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pop_q   <= pop_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read-return pipeline; last_q names the owner of the pop in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        id_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= pop_q;
      id_pipe[0]  <= pop_q ? last_q : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign pop       = pop_q;
  assign gnt       = gnt_q;
  assign rd_valid  = vld_pipe[RD_LAT-1];
  assign rd_id     = id_pipe[RD_LAT-1];
  assign led_error = (state_q == STALL);

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of read requesters, 2..8.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive grants to one requester before rotation, 1..15.
REQ-003 Parameter RD_LAT, default 1: FIFO memory read latency in cycles, 1..2.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  N_REQ  per-requester read request, level, held until granted.
REQ-007 empty_flag  input  1  FIFO empty indication from the read pointer side.
REQ-008 pop  output  1  single-cycle pop strobe to the FIFO read pointer.
REQ-009 gnt  output  N_REQ  one-hot grant, asserted in the same cycle as pop.
REQ-010 rd_valid  output  1  read data for the granted requester is on the FIFO data bus.
REQ-011 rd_id  output  ID_W  index of the requester owning the current rd_valid; ID_W = max(1, clog2(N_REQ)).
REQ-012 led_error  output  1  set while requests are pending and the FIFO is empty.

Function
REQ-013 States: IDLE, GRANT, STALL; state, gnt, pop, burst counter and last-winner index are registered.
REQ-014 IDLE: if no req bit is set, remain in IDLE with pop=0 and gnt=0.
REQ-015 IDLE: if any req bit is set and empty_flag=0, go to GRANT; if any req bit is set and empty_flag=1, go to STALL.
REQ-016 Winner selection is round-robin: search from (last_winner+1) mod N_REQ upward, wrapping; the first set req bit wins.
REQ-017 Exception to REQ-016: if the last winner still requests and burst_cnt < MAX_BURST, the last winner wins again.
REQ-018 GRANT: pop=1 and gnt=onehot(winner) for exactly one cycle per pop; at most one pop per cycle.
REQ-019 Latency: req and !empty_flag sampled at edge t, then pop/gnt are high during cycle t+1.
REQ-020 burst_cnt resets to 1 on a grant to a new winner, increments on a repeat grant, and saturates at MAX_BURST.
REQ-021 GRANT with requests still pending and empty_flag=0: stay in GRANT, issuing back-to-back pops.
REQ-022 Any state where empty_flag=1 at a sampling edge: issue no pop, and go to STALL if any req is set, else IDLE.
REQ-023 GRANT with no req set: go to IDLE.
REQ-024 STALL: led_error=1 and pop=0; leave to GRANT when empty_flag=0 and a request is pending, or to IDLE when req=0.
REQ-025 Outside STALL, led_error=0.
REQ-026 rd_valid/rd_id: delay pop and the winner index by RD_LAT cycles through a shift pipeline; rd_valid=1 exactly RD_LAT cycles after each pop.
REQ-027 A requester that drops req before being granted is simply skipped; no grant is issued to a non-requesting index.
REQ-028 A request arriving in the same cycle as empty_flag deasserting is eligible at that edge.

Reset
REQ-029 At a rising edge with rst_n=0: state=IDLE, pop=0, gnt=0, rd_valid=0, rd_id=0, led_error=0, burst_cnt=0, last_winner=N_REQ-1, so index 0 has first priority.
REQ-030 Reset mid-operation discards in-flight rd_valid pipeline entries; no rd_valid appears after reset for pops issued before it.

Structure
REQ-031 N_REQ, MAX_BURST, RD_LAT defaults and the state enum type arb_state_t belong in fifo_pkg, next to addr_t and W_DEPTH.
REQ-032 One sub-module, rr_pick: combinational round-robin priority picker (req vector, start index) -> (valid, winner index).
REQ-033 The FSM, burst counter and RD_LAT pipeline reside in fifo_rd_arbiter.

Verification
REQ-034 Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> all outputs 0; first grant after release is gnt=4'b0001.
REQ-035 Round robin, MAX_BURST=1: req=4'b1111 held, FIFO non-empty -> gnt sequence 0001,0010,0100,1000,0001, one pop per cycle.
REQ-036 Burst, MAX_BURST=4: req=4'b0011 held -> gnt 0001 x4, then 0010 x4, then 0001.
REQ-037 Empty: req=4'b0100 with empty_flag=1 for 3 cycles -> pop=0 and led_error=1 for 3 cycles; after empty_flag drops, gnt=0100 one cycle later and led_error=0.
REQ-038 Latency, RD_LAT=2: single req[2] pulse -> pop at t+1, rd_valid=1 with rd_id=2 at t+3, for one cycle only.
REQ-039 Reset mid-burst: assert rst_n=0 one cycle after a pop -> no rd_valid afterwards, and state returns to IDLE.
